// File: rtl/bdcpu_memory_responder.sv
// bdcpu memory responder: 16x8 RAM on the CPU bus plus a byte-stream
// program loader that holds the CPU in reset while it fills or clears RAM.
module bdcpu_memory_responder #(
   parameter logic [3:0]  LOAD_CMD       = 4'hA,
   parameter logic [3:0]  CLEAR_CMD      = 4'hC,
   parameter int unsigned RELEASE_CYCLES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       mem_output_enable,
   input  logic       mem_write_enable,
   input  logic [3:0] mem_address,
   inout  wire  [7:0] mem_data,
   input  logic       load_valid,
   input  logic [7:0] load_data,
   output logic       load_ready,
   output logic       cpu_reset,
   output logic       load_done,
   output logic       bad_cmd
);

   localparam int RW = (RELEASE_CYCLES < 2) ? 1 : $clog2(RELEASE_CYCLES + 1);

   typedef enum logic [2:0] {
      S_RUN,
      S_COUNT,
      S_DATA,
      S_CLEAR,
      S_RELEASE
   } state_e;

   state_e          state_q, state_d;
   logic [3:0]      addr_q, addr_d;
   logic [4:0]      remain_q, remain_d;
   logic [RW-1:0]   rel_q, rel_d;
   logic            from_load_q, from_load_d;
   logic            bad_q, bad_d;
   logic            cpu_reset_q;

   logic [7:0]      ram_q [16];
   logic            ram_we;
   logic [3:0]      ram_wa;
   logic [7:0]      ram_wd;
   logic            accept;
   logic            read_en;

   assign load_ready = (state_q == S_RUN) || (state_q == S_COUNT) ||
                       (state_q == S_DATA);
   assign accept     = load_valid & load_ready;
   assign cpu_reset  = cpu_reset_q;
   assign bad_cmd    = bad_q;
   assign load_done  = (state_q == S_RELEASE) && (rel_q == RW'(1)) &&
                       from_load_q;

   // The write strobe always wins, so the bus is never driven during a write
   assign read_en  = (state_q == S_RUN) && mem_output_enable &&
                     !mem_write_enable;
   assign mem_data = read_en ? ram_q[mem_address] : 8'bz;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remain_d    = remain_q;
      rel_d       = rel_q;
      from_load_d = from_load_q;
      bad_d       = bad_q;
      ram_we      = 1'b0;
      ram_wa      = addr_q;
      ram_wd      = load_data;
      unique case (state_q)
         S_RUN: begin
            if (mem_write_enable) begin
               ram_we = 1'b1;
               ram_wa = mem_address;
               ram_wd = mem_data;
            end
            if (accept) begin
               if (load_data[7:4] == LOAD_CMD) begin
                  addr_d  = load_data[3:0];
                  state_d = S_COUNT;
               end else if (load_data[7:4] == CLEAR_CMD) begin
                  addr_d  = 4'd0;
                  state_d = S_CLEAR;
               end else begin
                  bad_d = 1'b1;
               end
            end
         end
         S_COUNT: begin
            if (accept) begin
               if (load_data[4:0] == 5'd0 || load_data[4:0] > 5'd16)
                  remain_d = 5'd16;
               else
                  remain_d = load_data[4:0];
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               ram_we   = 1'b1;
               addr_d   = addr_q + 4'd1;
               remain_d = remain_q - 5'd1;
               if (remain_q == 5'd1) begin
                  state_d     = S_RELEASE;
                  rel_d       = RW'(RELEASE_CYCLES);
                  from_load_d = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            ram_we = 1'b1;
            ram_wd = 8'h00;
            addr_d = addr_q + 4'd1;
            if (addr_q == 4'hF) begin
               state_d     = S_RELEASE;
               rel_d       = RW'(RELEASE_CYCLES);
               from_load_d = 1'b1;
            end
         end
         S_RELEASE: begin
            rel_d = rel_q - RW'(1);
            if (rel_q == RW'(1)) begin
               state_d     = S_RUN;
               from_load_d = 1'b0;
            end
         end
         default: state_d = S_RELEASE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_RELEASE;
         addr_q      <= 4'd0;
         remain_q    <= 5'd0;
         rel_q       <= RW'(RELEASE_CYCLES);
         from_load_q <= 1'b0;
         bad_q       <= 1'b0;
         cpu_reset_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remain_q    <= remain_d;
         rel_q       <= rel_d;
         from_load_q <= from_load_d;
         bad_q       <= bad_d;
         cpu_reset_q <= (state_d == S_RUN);
      end
   end

   // Contents survive reset so a partial load is kept
   always_ff @(posedge clock) begin
      if (ram_we)
         ram_q[ram_wa] <= ram_wd;
   end

endmodule
